// File: rtl/control_unit.sv
// control_unit: multicycle fetch/decode/execute sequencer driving the RV-subset datapath strobes.
// Optional cycle/instruction counters are compiled in when UC_PERF_COUNTERS_EN is defined.
module control_unit #(
  parameter logic [2:0] NO_BRANCH_SEL = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       IR_load,
  output logic       PC_load,
  output logic       WE_reg,
  output logic       WE_mem,
  output logic [1:0] OP_MEM_I,
  output logic       ADD_SUB,
  output logic [2:0] select_flags,
  output logic       JAL,
  output logic       JALR,
  output logic       AUIPC,
  output logic       instr_done,
  output logic       illegal
`ifdef UC_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t     state_reg, state_next, done_state;
  logic [6:0] op_reg, op_next;
  logic [2:0] f3_reg, f3_next;
  logic       f7_reg, f7_next;

  logic       ir_load_next, pc_load_next, we_reg_next, we_mem_next;
  logic [1:0] op_mem_i_next;
  logic       add_sub_next;
  logic [2:0] select_flags_next;
  logic       jal_next, jalr_next, auipc_next, instr_done_next, illegal_next;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  assign done_state = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    f3_next    = f3_reg;
    f7_next    = f7_reg;
    case (state_reg)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        op_next    = opcode;
        f3_next    = funct3;
        f7_next    = funct7_5;
        state_next = is_legal(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (op_reg)
          OP_BRANCH:         state_next = done_state;
          OP_LOAD, OP_STORE: state_next = S_MEM;
          default:           state_next = S_WB;
        endcase
      end
      S_MEM:    state_next = (op_reg == OP_LOAD) ? S_WB : done_state;
      S_WB:     state_next = done_state;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded for the state being entered so they register in lock-step with it.
  always_comb begin
    ir_load_next      = 1'b0;
    pc_load_next      = 1'b0;
    we_reg_next       = 1'b0;
    we_mem_next       = 1'b0;
    op_mem_i_next     = 2'd0;
    add_sub_next      = 1'b0;
    select_flags_next = NO_BRANCH_SEL;
    jal_next          = 1'b0;
    jalr_next         = 1'b0;
    auipc_next        = 1'b0;
    instr_done_next   = 1'b0;
    illegal_next      = 1'b0;
    case (state_next)
      S_FETCH: ir_load_next = 1'b1;
      S_EXEC: begin
        case (op_next)
          OP_R:              add_sub_next  = f7_next;
          OP_IMM:            op_mem_i_next = 2'd2;
          OP_LOAD, OP_STORE: op_mem_i_next = 2'd1;
          OP_BRANCH: begin
            add_sub_next      = 1'b1;
            select_flags_next = f3_next;
            pc_load_next      = 1'b1;
            instr_done_next   = 1'b1;
          end
          OP_JAL:   begin op_mem_i_next = 2'd3; jal_next   = 1'b1; end
          OP_JALR:  begin op_mem_i_next = 2'd3; jalr_next  = 1'b1; end
          OP_AUIPC: begin op_mem_i_next = 2'd3; auipc_next = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        op_mem_i_next = 2'd1;
        if (op_next == OP_STORE) begin
          we_mem_next     = 1'b1;
          pc_load_next    = 1'b1;
          instr_done_next = 1'b1;
        end
      end
      S_WB: begin
        we_reg_next     = 1'b1;
        pc_load_next    = 1'b1;
        instr_done_next = 1'b1;
        case (op_next)
          OP_R:     add_sub_next  = f7_next;
          OP_IMM:   op_mem_i_next = 2'd2;
          OP_LOAD:  op_mem_i_next = 2'd1;
          OP_JAL:   begin op_mem_i_next = 2'd3; jal_next   = 1'b1; end
          OP_JALR:  begin op_mem_i_next = 2'd3; jalr_next  = 1'b1; end
          OP_AUIPC: begin op_mem_i_next = 2'd3; auipc_next = 1'b1; end
          default: ;
        endcase
      end
      S_TRAP:  illegal_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      op_reg       <= '0;
      f3_reg       <= '0;
      f7_reg       <= 1'b0;
      IR_load      <= 1'b0;
      PC_load      <= 1'b0;
      WE_reg       <= 1'b0;
      WE_mem       <= 1'b0;
      OP_MEM_I     <= 2'd0;
      ADD_SUB      <= 1'b0;
      select_flags <= NO_BRANCH_SEL;
      JAL          <= 1'b0;
      JALR         <= 1'b0;
      AUIPC        <= 1'b0;
      instr_done   <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      f3_reg       <= f3_next;
      f7_reg       <= f7_next;
      IR_load      <= ir_load_next;
      PC_load      <= pc_load_next;
      WE_reg       <= we_reg_next;
      WE_mem       <= we_mem_next;
      OP_MEM_I     <= op_mem_i_next;
      ADD_SUB      <= add_sub_next;
      select_flags <= select_flags_next;
      JAL          <= jal_next;
      JALR         <= jalr_next;
      AUIPC        <= auipc_next;
      instr_done   <= instr_done_next;
      illegal      <= illegal_next;
    end
  end

`ifdef UC_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state_reg != S_IDLE && state_reg != S_TRAP) cycle_count <= cycle_count + 32'd1;
      if (instr_done) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed literal checks plus randomized run against a cycle-indexed instruction model.
// Counter checks are included when UC_PERF_COUNTERS_EN is defined.
module tb_control_unit;

  localparam logic [2:0] NB = 3'b010;
  localparam logic Z = 1'b0;
  localparam logic H = 1'b1;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [14:0] DEF = {4'b0000, 2'b00, 1'b0, 3'b010, 5'b00000};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7_5 = 1'b0;
  logic IR_load, PC_load, WE_reg, WE_mem, ADD_SUB, JAL, JALR, AUIPC, instr_done, illegal;
  logic [1:0] OP_MEM_I;
  logic [2:0] select_flags;
`ifdef UC_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_count;
  logic [31:0] m_cyc = 32'd0;
  logic [31:0] m_ins = 32'd0;
`endif

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .IR_load(IR_load), .PC_load(PC_load), .WE_reg(WE_reg), .WE_mem(WE_mem), .OP_MEM_I(OP_MEM_I),
    .ADD_SUB(ADD_SUB), .select_flags(select_flags), .JAL(JAL), .JALR(JALR), .AUIPC(AUIPC),
    .instr_done(instr_done), .illegal(illegal)
`ifdef UC_PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  logic [14:0] dut_vec;
  assign dut_vec = {IR_load, PC_load, WE_reg, WE_mem, OP_MEM_I, ADD_SUB, select_flags,
                    JAL, JALR, AUIPC, instr_done, illegal};

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_no = 0;

  // Model: k = 0 idle, -1 trapped, otherwise 1-based cycle number within the instruction.
  int k = 0;
  logic [6:0] m_op = 7'd0;
  logic [2:0] m_f3 = 3'd0;
  logic m_f7 = 1'b0;

  logic [6:0] legal_ops [0:7] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC};

  function automatic int instr_len(input logic [6:0] op);
    case (op)
      OP_LOAD:   return 5;
      OP_BRANCH: return 3;
      OP_R, OP_IMM, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC: return 4;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [14:0] mk(input logic ir, input logic pc, input logic wr, input logic wm,
                                     input logic [1:0] src, input logic as, input logic [2:0] sel,
                                     input logic j, input logic jr, input logic au,
                                     input logic d, input logic il);
    return {ir, pc, wr, wm, src, as, sel, j, jr, au, d, il};
  endfunction

  function automatic logic [14:0] exp_vec(input int kk, input logic [6:0] op,
                                          input logic [2:0] f3, input logic f7);
    logic last, as, wr, wm, j, jr, au;
    logic [1:0] src;
    logic [2:0] sel;
    if (kk == -1) return mk(Z, Z, Z, Z, 2'd0, Z, NB, Z, Z, Z, Z, H);
    if (kk == 1)  return mk(H, Z, Z, Z, 2'd0, Z, NB, Z, Z, Z, Z, Z);
    if (kk < 3)   return DEF;
    last = (kk == instr_len(op));
    src = 2'd0; as = Z; wr = Z; wm = Z; j = Z; jr = Z; au = Z; sel = NB;
    case (op)
      OP_R:      begin as = f7; wr = last; end
      OP_IMM:    begin src = 2'd2; wr = last; end
      OP_LOAD:   begin src = 2'd1; wr = last; end
      OP_STORE:  begin src = 2'd1; wm = last; end
      OP_BRANCH: begin as = H; sel = f3; end
      OP_JAL:    begin src = 2'd3; j = H; wr = last; end
      OP_JALR:   begin src = 2'd3; jr = H; wr = last; end
      OP_AUIPC:  begin src = 2'd3; au = H; wr = last; end
      default: ;
    endcase
    return mk(Z, last, wr, wm, src, as, sel, j, jr, au, last, Z);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k = 0;
`ifdef UC_PERF_COUNTERS_EN
      m_cyc = 32'd0;
      m_ins = 32'd0;
`endif
    end else begin
`ifdef UC_PERF_COUNTERS_EN
      if (k > 0) m_cyc = m_cyc + 32'd1;
      if (k >= 3 && k == instr_len(m_op)) m_ins = m_ins + 32'd1;
`endif
      if (k == 0) begin
        if (run) k = 1;
      end else if (k == 1) begin
        k = 2;
      end else if (k == 2) begin
        m_op = opcode; m_f3 = funct3; m_f7 = funct7_5;
        k = (instr_len(opcode) == 0) ? -1 : 3;
      end else if (k > 2) begin
        if (k == instr_len(m_op)) k = run ? 1 : 0;
        else k = k + 1;
      end
    end
  end

  task automatic check_model();
    logic [14:0] e;
    e = exp_vec(k, m_op, m_f3, m_f7);
    tests_run++;
    if (dut_vec !== e) begin
      tests_failed++;
      $display("FAIL model cycle %0d k=%0d op=%b: got %h required %h", cyc_no, k, m_op, dut_vec, e);
    end
`ifdef UC_PERF_COUNTERS_EN
    tests_run++;
    if (cycle_count !== m_cyc || instr_count !== m_ins) begin
      tests_failed++;
      $display("FAIL counters cycle %0d: got cyc=%0d ins=%0d required cyc=%0d ins=%0d",
               cyc_no, cycle_count, instr_count, m_cyc, m_ins);
    end
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_no++;
    check_model();
  endtask

  task automatic check_lit(input string name, input logic [14:0] e);
    tests_run++;
    if (dut_vec !== e) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h", name, dut_vec, e);
    end else begin
      $display("[TB] cycle %0d %s ok (%h)", cyc_no, name, dut_vec);
    end
  endtask

  logic [6:0] jops [0:2] = '{OP_JAL, OP_JALR, OP_AUIPC};

  initial begin
    tick(); tick();
    check_lit("reset_idle", DEF);

    reset = 1'b1; run = 1'b1; opcode = OP_R; funct3 = 3'b000; funct7_5 = 1'b1;
    tick(); check_lit("fetch_first", mk(H, Z, Z, Z, 2'd0, Z, NB, Z, Z, Z, Z, Z));
    tick(); check_lit("rsub_decode", DEF);
    tick(); check_lit("rsub_exec", mk(Z, Z, Z, Z, 2'd0, H, NB, Z, Z, Z, Z, Z));
    opcode = OP_LOAD; funct7_5 = 1'b0;
    tick(); check_lit("rsub_wb", mk(Z, H, H, Z, 2'd0, H, NB, Z, Z, Z, H, Z));

    tick(); check_lit("load_fetch", mk(H, Z, Z, Z, 2'd0, Z, NB, Z, Z, Z, Z, Z));
    tick(); check_lit("load_decode", DEF);
    tick(); check_lit("load_exec", mk(Z, Z, Z, Z, 2'd1, Z, NB, Z, Z, Z, Z, Z));
    opcode = OP_STORE;
    tick(); check_lit("load_mem", mk(Z, Z, Z, Z, 2'd1, Z, NB, Z, Z, Z, Z, Z));
    tick(); check_lit("load_wb", mk(Z, H, H, Z, 2'd1, Z, NB, Z, Z, Z, H, Z));

    tick(); tick();
    tick(); check_lit("store_exec", mk(Z, Z, Z, Z, 2'd1, Z, NB, Z, Z, Z, Z, Z));
    opcode = OP_BRANCH; funct3 = 3'b000;
    tick(); check_lit("store_mem", mk(Z, H, Z, H, 2'd1, Z, NB, Z, Z, Z, H, Z));

    tick(); tick();
    tick(); check_lit("beq_exec", mk(Z, H, Z, Z, 2'd0, H, 3'b000, Z, Z, Z, H, Z));
    funct3 = 3'b001;
    tick(); check_lit("bne_fetch", mk(H, Z, Z, Z, 2'd0, Z, NB, Z, Z, Z, Z, Z));
    tick();
    tick(); check_lit("bne_exec", mk(Z, H, Z, Z, 2'd0, H, 3'b001, Z, Z, Z, H, Z));

    for (int i = 0; i < 3; i++) begin
      logic j, jr, au;
      j = (i == 0); jr = (i == 1); au = (i == 2);
      opcode = jops[i];
      tick(); tick();
      tick(); check_lit("jump_exec", mk(Z, Z, Z, Z, 2'd3, Z, NB, j, jr, au, Z, Z));
      tick(); check_lit("jump_wb", mk(Z, H, H, Z, 2'd3, Z, NB, j, jr, au, H, Z));
    end

    opcode = OP_R; funct7_5 = 1'b0;
    tick(); tick();
    tick(); check_lit("radd_exec", mk(Z, Z, Z, Z, 2'd0, Z, NB, Z, Z, Z, Z, Z));
    reset = 1'b0;
    #1; check_lit("reset_mid_exec", DEF);
    tick(); check_lit("reset_held", DEF);

    reset = 1'b1; run = 1'b1; opcode = 7'b1111111;
    tick(); tick();
    for (int i = 0; i < 12; i++) begin
      run = 1'($urandom);
      tick(); check_lit("trap_hold", mk(Z, Z, Z, Z, 2'd0, Z, NB, Z, Z, Z, Z, H));
    end
`ifdef UC_PERF_COUNTERS_EN
    tests_run++;
    if (cycle_count !== 32'd2 || instr_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL trap_counters: got cyc=%0d ins=%0d required cyc=2 ins=0", cycle_count, instr_count);
    end
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) != 0) opcode = legal_ops[$urandom_range(0, 7)];
      else opcode = 7'($urandom);
      funct3 = 3'($urandom);
      funct7_5 = 1'($urandom);
      if (k == -1) reset = ($urandom_range(0, 9) != 0);
      else reset = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle control FSM that sits directly upstream of the instruction datapath.
- Decodes the RV-subset instruction held in the datapath IR and sequences every datapath control strobe: IR_load, PC_load, WE_reg, WE_mem, OP_MEM_I, ADD_SUB, select_flags, JAL, JALR, AUIPC.
- Replaces hand-driven control vectors with an autonomous fetch/decode/execute loop.

Parameters:
- NO_BRANCH_SEL, 3'b010, select_flags code driven when no branch is active (unused branch funct3).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  level enable; FSM leaves IDLE/FETCH only while high.
- opcode  input  7  IR[6:0] from datapath.
- funct3  input  3  IR[14:12].
- funct7_5  input  1  IR[30]; selects sub for R-type.
- IR_load  output  1  IR write strobe.
- PC_load  output  1  PC write strobe.
- WE_reg  output  1  register-file write enable.
- WE_mem  output  1  data-memory write enable.
- OP_MEM_I  output  2  datapath source select: 0 = ALU reg-reg, 1 = load/store address, 2 = immediate, 3 = PC-relative/link.
- ADD_SUB  output  1  0 = add, 1 = sub.
- select_flags  output  3  branch condition select (funct3 when branching).
- JAL, JALR, AUIPC  output  1 each  PC-path selects.
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
- illegal  output  1  sticky; unknown opcode decoded.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. State register is async-cleared to IDLE when reset=0.
- All outputs are Moore outputs, decoded from the registered state plus op_q/f3_q/f7_q.
- op_q/f3_q/f7_q latch opcode/funct3/funct7_5 in DECODE and are held until the next DECODE.
- Reset/default output values: all strobes 0, OP_MEM_I=0, ADD_SUB=0, select_flags=NO_BRANCH_SEL, JAL/JALR/AUIPC=0, instr_done=0, illegal=0.
- IDLE: go to FETCH if run=1, else stay.
- FETCH: IR_load=1 for exactly one cycle, then go to DECODE.
- DECODE: no strobes asserted. Go to EXEC for a legal opcode, else go to TRAP.
- Per-class sequences (cycles counted from FETCH):
  - R-type 0110011: EXEC OP_MEM_I=0, ADD_SUB=f7_q. WB holds the same values with WE_reg=1, PC_load=1. 4 cycles.
  - OP-IMM 0010011: as R-type but OP_MEM_I=2, ADD_SUB=0. 4 cycles.
  - LOAD 0000011: EXEC OP_MEM_I=1. MEM OP_MEM_I=1. WB OP_MEM_I=1, WE_reg=1, PC_load=1. 5 cycles.
  - STORE 0100011: EXEC OP_MEM_I=1. MEM OP_MEM_I=1, WE_mem=1, PC_load=1 (last cycle). 4 cycles.
  - BRANCH 1100011: EXEC ADD_SUB=1, select_flags=f3_q, PC_load=1 (last cycle). 3 cycles. The datapath resolves taken/not-taken.
  - JAL 1101111, JALR 1100111, AUIPC 0010111: EXEC OP_MEM_I=3 with the matching select high. WB keeps it high with WE_reg=1, PC_load=1. 4 cycles.
- After the last cycle: go to FETCH if run=1, else IDLE. instr_done=1 on that last cycle.
- WE_reg, WE_mem and PC_load are each high for exactly one cycle per instruction; never two in a row.
- run dropping mid-instruction does not abort; the instruction completes.
- TRAP: illegal=1 and stays 1; all strobes are 0; the FSM stays in TRAP until reset.
- Reset asserted mid-instruction: immediate return to IDLE, all outputs at defaults, no partial write strobe after the reset edge.

Optional Feature:
- Macro: UC_PERF_COUNTERS_EN.
- Defined: adds output ports cycle_count [31:0] and instr_count [31:0].
  - cycle_count increments every clock while the state is not IDLE or TRAP.
  - instr_count increments on each instr_done.
  - Both are async-cleared by reset and wrap modulo 2^32.
- Undefined: both ports and all counter logic are absent. FSM behaviour is identical either way.

Test Plan:
- Reset: reset=0 mid-EXEC of an R-type -> next cycle all outputs at defaults. After release with run=1 -> IR_load=1 in the first cycle.
- R-type sub: opcode 0110011, funct7_5=1 -> ADD_SUB=1 in EXEC and WB; WE_reg=1 and PC_load=1 only in cycle 4; instr_done=1 in cycle 4.
- Load then store back-to-back: LOAD -> WE_reg pulses in cycle 5. STORE -> WE_mem=1 with PC_load=1 in cycle 4, WE_reg=0 throughout. OP_MEM_I=1 in all EXEC/MEM/WB cycles.
- BEQ (funct3=000) then BNE (001) -> select_flags=000 then 001 in the respective EXEC cycles, PC_load=1 in cycle 3 of each, NO_BRANCH_SEL in every other cycle.
- JAL/JALR/AUIPC -> OP_MEM_I=3 and only the matching select high for cycles 3–4; WE_reg=1 in cycle 4.
- Illegal opcode 1111111 -> TRAP, illegal=1 held for 10+ cycles with no strobes; with UC_PERF_COUNTERS_EN, cycle_count frozen and instr_count unchanged.
